// File: rtl/tcb_arbiter.sv
// tcb_arbiter: round-robin arbiter sharing one TCB subordinate between
// MAN_N TCB managers. The request path is combinational (same-cycle grant).
// Read responses return to the issuing manager DLY cycles later. A small
// ownership pipeline tracks which manager each response belongs to.
// Optional build macro: TCB_ARB_LOCK_EN enables locked (atomic) sequences
// driven by man_lck.
`timescale 1ns/1ps

module tcb_arbiter #(
  parameter int MAN_N = 2,
  parameter int ABW   = 32,
  parameter int DBW   = 32,
  parameter int BEW   = DBW/8,
  parameter int DLY   = 1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAN_N-1:0]     man_vld,
  output logic [MAN_N-1:0]     man_rdy,
  input  logic [MAN_N-1:0]     man_wen,
  input  logic [MAN_N*ABW-1:0] man_adr,
  input  logic [MAN_N*3-1:0]   man_siz,
  input  logic [MAN_N*BEW-1:0] man_ben,
  input  logic [MAN_N*DBW-1:0] man_wdt,
  input  logic [MAN_N-1:0]     man_lck,
  output logic [MAN_N*DBW-1:0] man_rdt,
  output logic [MAN_N-1:0]     man_err,
  output logic                 sub_vld,
  input  logic                 sub_rdy,
  output logic                 sub_wen,
  output logic [ABW-1:0]       sub_adr,
  output logic [2:0]           sub_siz,
  output logic [BEW-1:0]       sub_ben,
  output logic [DBW-1:0]       sub_wdt,
  input  logic [DBW-1:0]       sub_rdt,
  input  logic                 sub_err
);

  localparam int IW  = (MAN_N > 1) ? $clog2(MAN_N) : 1;
  localparam int IW1 = IW + 1;

  // arbitration state
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gidx;
  logic             r_hld;
`ifdef TCB_ARB_LOCK_EN
  logic             r_lk;
`endif

  // grant and handshake
  logic             w_gnt_vld;
  logic [IW-1:0]    w_gnt_idx;
  logic [MAN_N-1:0] w_gnt;
  logic             w_xfer;
  logic             w_stall;
  logic [IW-1:0]    w_ptr_nxt;

  // response owner at the output end of the ownership pipeline
  logic             w_own_vld;
  logic [IW-1:0]    w_own_idx;

  // (base + ofs) mod MAN_N, valid for base, ofs < MAN_N
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                             input logic [IW-1:0] ofs);
    logic [IW1-1:0] sum;
    sum = {1'b0, base} + {1'b0, ofs};
    sum = (sum >= IW1'(MAN_N)) ? (sum - IW1'(MAN_N)) : sum;
    return sum[IW-1:0];
  endfunction

  // Select the granted manager: held index during a stall, locked owner, else round-robin from ptr
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (r_hld) begin
      w_gnt_idx = r_gidx;
      w_gnt_vld = man_vld[r_gidx];
    end
`ifdef TCB_ARB_LOCK_EN
    else if (r_lk) begin
      w_gnt_idx = r_ptr;
      w_gnt_vld = man_vld[r_ptr];
    end
`endif
    else begin
      // scan from lowest priority to highest so the candidate closest to ptr wins
      for (int k = MAN_N-1; k >= 0; k--) begin
        w_gnt_idx = man_vld[wrap_add(r_ptr, IW'(k))] ? wrap_add(r_ptr, IW'(k)) : w_gnt_idx;
      end
      w_gnt_vld = |man_vld;
    end
  end

  // One-hot grant vector derived from the granted index
  always_comb begin
    w_gnt = '0;
    if (w_gnt_vld) begin
      w_gnt = MAN_N'(1) << w_gnt_idx;
    end else begin
      w_gnt = '0;
    end
  end

  assign w_xfer    = w_gnt_vld & sub_rdy;
  assign w_stall   = w_gnt_vld & ~sub_rdy;
  assign w_ptr_nxt = wrap_add(w_gnt_idx, IW'(1));
  assign man_rdy   = w_gnt & {MAN_N{sub_rdy & ~rst}};

  // Route the granted manager's request fields to the subordinate port
  always_comb begin
    sub_vld = w_gnt_vld;
    sub_wen = 1'b0;
    sub_adr = '0;
    sub_siz = 3'd0;
    sub_ben = '0;
    sub_wdt = '0;
    if (w_gnt_vld) begin
      sub_wen = man_wen[w_gnt_idx];
      sub_adr = man_adr[w_gnt_idx*ABW +: ABW];
      sub_siz = man_siz[w_gnt_idx*3 +: 3];
      sub_ben = man_ben[w_gnt_idx*BEW +: BEW];
      sub_wdt = man_wdt[w_gnt_idx*DBW +: DBW];
    end else begin
      sub_wen = 1'b0;
    end
  end

  // Priority pointer, stall hold and (optionally) lock state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gidx <= '0;
      r_hld  <= 1'b0;
`ifdef TCB_ARB_LOCK_EN
      r_lk   <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_hld <= 1'b0;
`ifdef TCB_ARB_LOCK_EN
      if (man_lck[w_gnt_idx]) begin
        r_lk  <= 1'b1;
        r_ptr <= w_gnt_idx;
      end else begin
        r_lk  <= 1'b0;
        r_ptr <= w_ptr_nxt;
      end
`else
      r_ptr <= w_ptr_nxt;
`endif
    end else if (w_stall) begin
      r_hld  <= 1'b1;
      r_gidx <= w_gnt_idx;
    end else begin
      // idle, or the held manager withdrew its request: release the hold
      r_hld <= 1'b0;
    end
  end

`ifndef TCB_ARB_LOCK_EN
  logic w_unused_lck;
  assign w_unused_lck = ^man_lck;
`endif

  generate
    if (DLY == 0) begin : g_own_comb
      assign w_own_vld = w_xfer & ~sub_wen;
      assign w_own_idx = w_gnt_idx;
    end else begin : g_own_pipe
      logic [DLY-1:0] r_pv;
      logic [IW-1:0]  r_pi [DLY];

      // Shift read ownership {valid, index} down the DLY-deep pipeline
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pv <= '0;
          for (int s = 0; s < DLY; s++) begin
            r_pi[s] <= '0;
          end
        end else begin
          r_pv[0] <= w_xfer & ~sub_wen;
          r_pi[0] <= w_gnt_idx;
          for (int s = 1; s < DLY; s++) begin
            r_pv[s] <= r_pv[s-1];
            r_pi[s] <= r_pi[s-1];
          end
        end
      end

      assign w_own_vld = r_pv[DLY-1];
      assign w_own_idx = r_pi[DLY-1];
    end
  endgenerate

  // Deliver the subordinate response to its owner only; everyone else sees zero
  always_comb begin
    man_rdt = '0;
    man_err = '0;
    if (w_own_vld && !rst) begin
      man_rdt[w_own_idx*DBW +: DBW] = sub_rdt;
      man_err[w_own_idx]            = sub_err;
    end else begin
      man_rdt = '0;
      man_err = '0;
    end
  end

endmodule

// File: tb/tb_tcb_arbiter.sv
// Scoreboard bench for tcb_arbiter (MAN_N=4, DLY=2, 16-bit bus).
// Stimulus pushes expected requests/responses; a negedge monitor pops and
// compares whenever the DUT presents sub_vld or a routed response.
`timescale 1ns/1ps

module tb_tcb_arbiter;
  localparam int MN = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int DL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [MN-1:0]    man_vld, man_rdy, man_wen, man_lck, man_err;
  logic [MN*AW-1:0] man_adr;
  logic [MN*3-1:0]  man_siz;
  logic [MN*BW-1:0] man_ben;
  logic [MN*DW-1:0] man_wdt, man_rdt;
  logic             sub_vld, sub_rdy, sub_wen, sub_err;
  logic [AW-1:0]    sub_adr;
  logic [2:0]       sub_siz;
  logic [BW-1:0]    sub_ben;
  logic [DW-1:0]    sub_wdt, sub_rdt;

  always #5 clk = ~clk;

  tcb_arbiter #(.MAN_N(MN), .ABW(AW), .DBW(DW), .BEW(BW), .DLY(DL)) dut (
    .clk(clk), .rst(rst),
    .man_vld(man_vld), .man_rdy(man_rdy), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_ben(man_ben), .man_wdt(man_wdt), .man_lck(man_lck),
    .man_rdt(man_rdt), .man_err(man_err),
    .sub_vld(sub_vld), .sub_rdy(sub_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
    .sub_siz(sub_siz), .sub_ben(sub_ben), .sub_wdt(sub_wdt),
    .sub_rdt(sub_rdt), .sub_err(sub_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // subordinate read data tags each cycle so a late/early response is visible
  assign sub_rdt = {8'hA5, cyc[7:0]};

  typedef struct packed { logic [1:0] idx; logic wen; logic [3:0] rdy; } req_t;
  typedef struct packed { logic [31:0] due; logic [1:0] idx; logic err; } rsp_t;
  req_t q_req[$];
  rsp_t q_rsp[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_req(input int idx, input logic [3:0] rdy, input logic wen);
    req_t r;
    r.idx = idx[1:0];
    r.wen = wen;
    r.rdy = rdy;
    q_req.push_back(r);
  endtask

  task automatic exp_rsp(input int dly, input int idx, input logic err);
    rsp_t r;
    r.due = cyc + dly;
    r.idx = idx[1:0];
    r.err = err;
    q_rsp.push_back(r);
  endtask

  task automatic step(input logic [3:0] vld, input logic [3:0] wen, input logic [3:0] lck,
                      input logic rdy, input logic err);
    man_vld = vld;
    man_wen = wen;
    man_lck = lck;
    sub_rdy = rdy;
    sub_err = err;
    @(posedge clk);
    #1;
  endtask

  // monitor: compare DUT outputs against the scoreboard queues
  always @(negedge clk) begin
    req_t          er;
    rsp_t          es;
    logic [15:0]   ea;
    logic [63:0]   erdt;
    logic [3:0]    eerr;
    if (rst) begin
      check("rst_rdy", 64'(man_rdy), 64'd0);
      check("rst_rdt", man_rdt, 64'd0);
      check("rst_err", 64'(man_err), 64'd0);
    end else begin
      if (sub_vld) begin
        if (q_req.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL req_unexpected: got adr %h expected no request (cycle %0d)", sub_adr, cyc);
        end else begin
          er = q_req.pop_front();
          ea = 16'h0010 * (16'(er.idx) + 16'd1);
          check("sub_adr", 64'(sub_adr), 64'(ea));
          check("sub_wdt", 64'(sub_wdt), 64'(16'hD000 | 16'(er.idx)));
          check("sub_wen", 64'(sub_wen), 64'(er.wen));
          check("man_rdy", 64'(man_rdy), 64'(er.rdy));
        end
      end else begin
        check("rdy_idle", 64'(man_rdy), 64'd0);
      end
      if ((|man_rdt) || (|man_err)) begin
        if (q_rsp.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rdt %h err %b expected none (cycle %0d)", man_rdt, man_err, cyc);
        end else begin
          es   = q_rsp.pop_front();
          erdt = '0;
          erdt[es.idx*16 +: 16] = {8'hA5, es.due[7:0]};
          eerr = es.err ? (4'b0001 << es.idx) : 4'b0000;
          check("rsp_cycle", 64'(cyc), 64'(es.due));
          check("man_rdt", man_rdt, erdt);
          check("man_err", 64'(man_err), 64'(eerr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    int ga [5] = '{0, 1, 0, 1, 0};
    rst     = 1'b1;
    man_vld = '0; man_wen = '0; man_lck = '0;
    man_adr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    man_wdt = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    man_siz = {4{3'd2}};
    man_ben = {4{2'b11}};
    sub_rdy = 1'b0;
    sub_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // A: managers 0 and 1 reading back-to-back alternate 0,1,0,1,0
    for (int k = 0; k < 5; k++) begin
      exp_req(ga[k], (ga[k] == 0) ? 4'b0001 : 4'b0010, 1'b0);
      exp_rsp(2, ga[k], 1'b0);
      step(4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0);
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // B: ptr=1, man0 stalls 3 cycles, man1 arrives mid-stall and must wait
    exp_req(0, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    exp_req(0, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0);
    exp_req(0, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0);
    exp_req(0, 4'b0001, 1'b0);
    exp_rsp(2, 0, 1'b0);
    step(4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0);
    exp_req(1, 4'b0010, 1'b0);
    exp_rsp(2, 1, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // C: ptr=2, man0 write then man1 read; error reaches man1 only, write gets nothing
    exp_req(0, 4'b0001, 1'b1);
    step(4'b0011, 4'b0001, 4'b0000, 1'b1, 1'b0);
    exp_req(1, 4'b0010, 1'b0);
    exp_rsp(2, 1, 1'b1);
    step(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // D: single requester man3 every cycle, then all request -> 0,1,2,3 after wrap
    for (int k = 0; k < 5; k++) begin
      exp_req(3, 4'b1000, 1'b1);
      step(4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_req(k, 4'b0001 << k, 1'b1);
      step(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0);
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // E: reset while a read is in flight; response dropped, ptr back to 0
    exp_req(2, 4'b0100, 1'b0);
    step(4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0);
    rst = 1'b1;
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    rst = 1'b0;
    exp_req(2, 4'b0100, 1'b0);
    exp_rsp(2, 2, 1'b0);
    step(4'b1100, 4'b0000, 4'b0000, 1'b1, 1'b0);
    exp_req(3, 4'b1000, 1'b0);
    exp_rsp(2, 3, 1'b0);
    step(4'b1100, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

`ifdef TCB_ARB_LOCK_EN
    // F: man1 locks twice; man0 excluded even while bus idle, granted after unlock
    exp_req(1, 4'b0010, 1'b1);
    step(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    exp_req(1, 4'b0010, 1'b1);
    step(4'b0011, 4'b0011, 4'b0010, 1'b1, 1'b0);
    step(4'b0001, 4'b0011, 4'b0000, 1'b1, 1'b0);
    exp_req(1, 4'b0010, 1'b1);
    step(4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0);
    exp_req(0, 4'b0001, 1'b1);
    step(4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
`endif

    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    check("req_queue_drained", 64'(q_req.size()), 64'd0);
    check("rsp_queue_drained", 64'(q_rsp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tcb_arbiter.md
Name: tcb_arbiter

Overview:
- Round-robin arbiter that shares one TCB subordinate port between MAN_N TCB manager ports.
- Typical use: CPU instruction fetch, CPU load/store and a debug/DMA manager feeding one tightly coupled memory or peripheral bus.
- Request path is combinational (same-cycle grant, no added request latency).
- Responses are returned to the issuing manager after the fixed TCB read delay DLY, tracked by an internal ownership pipeline.

Parameters:
- MAN_N, 2, number of manager ports (2..8)
- ABW, 32, address width
- DBW, 32, data width (multiple of 8)
- BEW, DBW/8, byte enable width
- DLY, 1, subordinate response delay in cycles (0..4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- man_vld  in  MAN_N  per-manager request valid
- man_rdy  out  MAN_N  per-manager request ready
- man_wen  in  MAN_N  write enable
- man_adr  in  MAN_N*ABW  address
- man_siz  in  MAN_N*3  transfer size, tcb_size_t encoding (0=BYTE .. 4=QUAD)
- man_ben  in  MAN_N*BEW  byte enables
- man_wdt  in  MAN_N*DBW  write data
- man_lck  in  MAN_N  lock request (used only with TCB_ARB_LOCK_EN)
- man_rdt  out  MAN_N*DBW  read data, routed to owner
- man_err  out  MAN_N  error response, routed to owner
- sub_vld  out  1  subordinate request valid
- sub_rdy  in  1  subordinate ready
- sub_wen, sub_adr, sub_siz, sub_ben, sub_wdt  out  1/ABW/3/BEW/DBW  muxed request
- sub_rdt  in  DBW  subordinate read data
- sub_err  in  1  subordinate error

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset state:
  - priority pointer ptr=0, hold flag hld=0, ownership pipeline cleared.
  - All man_rdt=0, man_err=0, man_rdy=0.
  - sub_vld follows man_vld combinationally.
- Arbitration (combinational):
  - If hld=0, grant the first man_vld[i] found searching i=ptr, ptr+1, ... mod MAN_N.
  - If hld=1, grant the registered index gidx.
  - Exactly one-hot or zero grant.
- Request mux:
  - sub_vld = |man_vld (held grant: man_vld[gidx]).
  - sub_* = fields of the granted manager; 0 when nothing is granted.
- Ready: man_rdy[i] = sub_rdy & gnt[i]. Non-granted managers see rdy=0.
- Transfer: sub_vld & sub_rdy.
  - On a transfer from manager i: ptr <= (i+1) mod MAN_N, hld <= 0.
- Stall: sub_vld & !sub_rdy.
  - hld <= 1 and gidx <= current grant; the grant is frozen until the transfer completes.
  - A higher-priority requester arriving mid-stall must not preempt.
  - A manager dropping vld mid-stall is a protocol violation; the arbiter releases hld the next cycle.
- Ownership pipeline: DLY stages of {valid, index}.
  - Stage 0 is loaded with {transfer & !wen, grant index} each cycle.
  - The stage at depth DLY selects the response owner.
- Response routing:
  - Owner j gets man_rdt[j]=sub_rdt and man_err[j]=sub_err.
  - All other managers get 0.
  - Writes produce no routed response.
  - DLY=0: routing is combinational from the current transfer.
- Back-to-back: a new grant is issued every cycle with sub_rdy=1.
  - Two managers continuously requesting alternate strictly A,B,A,B.
- Single requester: granted every cycle regardless of ptr; ptr still advances past it.
- ptr wrap: after MAN_N-1 comes 0.
- Reset mid-operation: pipeline flushed; responses in flight are dropped (outputs 0).

Optional Feature:
- Macro: TCB_ARB_LOCK_EN.
- Defined:
  - A transfer with man_lck[i]=1 sets lock flag lk=1 and keeps ptr=i.
  - While lk=1, only manager i is eligible; other managers see rdy=0 even if the bus is idle.
  - lk clears after a transfer from i with man_lck[i]=0.
  - Reset clears lk. Used for atomic read-modify-write sequences.
- Undefined: man_lck ignored, no lock logic synthesized, ptr rotates after every transfer.

Test Plan:
- MAN_N=2, DLY=1, both vld=1 continuously, sub_rdy=1 -> grants 0,1,0,1; man0 read adr 0x10 returns sub_rdt 0xAAAA_0001 only on man_rdt[0] one cycle later, man_rdt[1]=0.
- Man0 request, sub_rdy=0 for 3 cycles, man1 raises vld in cycle 2 -> sub_adr stays man0's, man_rdy[1]=0 until man0 completes in cycle 4, man1 granted in cycle 5.
- Mixed: man0 write then man1 read, DLY=2 -> only man1 receives sub_rdt/err two cycles after its transfer; sub_err=1 reaches man_err[1] only.
- MAN_N=4, only man3 requesting for 5 cycles -> granted every cycle; then all request -> order 0,1,2,3 (ptr wrapped to 0).
- Assert rst while a read is in the DLY pipeline -> man_rdt/man_err 0 immediately, ptr=0 after release, first grant to lowest valid index.
- TCB_ARB_LOCK_EN: man1 transfers with lck=1 twice, man0 vld=1 throughout -> man0 rdy=0 until man1 transfers with lck=0, then man0 granted next.
